// File: rtl/ps2_host_tx.sv
// ps2_host_tx: host-to-device PS/2 command transmitter.
// Runs inhibit, request-to-send, device-clocked shift of an 11-bit frame
// (start, 8 data LSB first, odd parity, stop) and samples the device acknowledge.
// Optional feature macro: PS2_TX_TIMEOUT_EN enables the inter-edge watchdog.
// Pin drivers are open-drain enables: *_oe = 1 pulls the line low.
module ps2_host_tx #(
  parameter int unsigned INHIBIT_CYCLES = 5000,
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx_done,
  output logic       tx_error,
  output logic       busy,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe
);

  localparam int unsigned FRAME_W = 10;
  localparam int unsigned EDGE_W  = 4;
  localparam int unsigned INH_W   = (INHIBIT_CYCLES > 1) ? $clog2(INHIBIT_CYCLES) : 1;

  // Elaboration-time guard on parameter ranges
  if (INHIBIT_CYCLES < 2 || TIMEOUT_CYCLES < 2) begin : g_param_check
    $error("ps2_host_tx: INHIBIT_CYCLES and TIMEOUT_CYCLES must be at least 2");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_INHIBIT,
    S_RTS,
    S_SHIFT,
    S_ACK,
    S_WAIT_IDLE,
    S_DONE,
    S_ERROR
  } state_t;

  state_t               state_q;
  logic [FRAME_W-1:0]   frame_q;
  logic [EDGE_W-1:0]    edge_cnt_q;
  logic [INH_W-1:0]     inh_cnt_q;
  logic                 tx_ready_q;
  logic                 tx_done_q;
  logic                 tx_error_q;
  logic                 busy_q;
  logic                 clk_oe_q;
  logic                 data_oe_q;

  logic                 clk_s1_q;
  logic                 clk_s2_q;
  logic                 clk_prev_q;
  logic                 data_s1_q;
  logic                 data_s2_q;

  logic                 fall;
  logic                 timeout_hit;

  // Two-flop synchronisers plus one history flop for clock edge detection
  always_ff @(posedge clock) begin
    if (reset) begin
      clk_s1_q   <= 1'b1;
      clk_s2_q   <= 1'b1;
      clk_prev_q <= 1'b1;
      data_s1_q  <= 1'b1;
      data_s2_q  <= 1'b1;
    end else begin
      clk_s1_q   <= ps2_clk_in;
      clk_s2_q   <= clk_s1_q;
      clk_prev_q <= clk_s2_q;
      data_s1_q  <= ps2_data_in;
      data_s2_q  <= data_s1_q;
    end
  end

  assign fall = clk_prev_q & ~clk_s2_q;

`ifdef PS2_TX_TIMEOUT_EN
  localparam int unsigned WDOG_W = 20;

  logic [WDOG_W-1:0] wdog_q;

  // Saturating watchdog, cleared on SHIFT entry and on every device clock fall
  always_ff @(posedge clock) begin
    if (reset) begin
      wdog_q <= '0;
    end else if (state_q == S_RTS || fall) begin
      wdog_q <= '0;
    end else if (wdog_q != '1) begin
      wdog_q <= wdog_q + WDOG_W'(1);
    end
  end

  assign timeout_hit = (wdog_q >= WDOG_W'(TIMEOUT_CYCLES - 1));
`else
  assign timeout_hit = 1'b0;
`endif

  // Transmit sequencer with registered outputs
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= S_IDLE;
      frame_q    <= '0;
      edge_cnt_q <= '0;
      inh_cnt_q  <= '0;
      tx_ready_q <= 1'b1;
      tx_done_q  <= 1'b0;
      tx_error_q <= 1'b0;
      busy_q     <= 1'b0;
      clk_oe_q   <= 1'b0;
      data_oe_q  <= 1'b0;
    end else begin
      tx_done_q  <= 1'b0;
      tx_error_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (tx_valid && tx_ready_q) begin
            frame_q    <= {1'b1, ~^tx_data, tx_data};
            edge_cnt_q <= '0;
            inh_cnt_q  <= '0;
            tx_ready_q <= 1'b0;
            busy_q     <= 1'b1;
            clk_oe_q   <= 1'b1;
            data_oe_q  <= 1'b0;
            state_q    <= S_INHIBIT;
          end
        end
        S_INHIBIT: begin
          if (inh_cnt_q == INH_W'(INHIBIT_CYCLES - 1)) begin
            data_oe_q <= 1'b1;
            state_q   <= S_RTS;
          end else begin
            inh_cnt_q <= inh_cnt_q + INH_W'(1);
          end
        end
        S_RTS: begin
          // Release clock; data stays low as the start bit
          clk_oe_q <= 1'b0;
          state_q  <= S_SHIFT;
        end
        S_SHIFT: begin
          if (timeout_hit) begin
            data_oe_q  <= 1'b0;
            tx_error_q <= 1'b1;
            state_q    <= S_ERROR;
          end else if (fall) begin
            data_oe_q  <= ~frame_q[0];
            frame_q    <= {1'b0, frame_q[FRAME_W-1:1]};
            edge_cnt_q <= edge_cnt_q + EDGE_W'(1);
            if (edge_cnt_q == EDGE_W'(9)) begin
              state_q <= S_ACK;
            end
          end
        end
        S_ACK: begin
          if (timeout_hit) begin
            tx_error_q <= 1'b1;
            state_q    <= S_ERROR;
          end else if (fall) begin
            if (!data_s2_q) begin
              state_q <= S_WAIT_IDLE;
            end else begin
              tx_error_q <= 1'b1;
              state_q    <= S_ERROR;
            end
          end
        end
        S_WAIT_IDLE: begin
          if (timeout_hit) begin
            tx_error_q <= 1'b1;
            state_q    <= S_ERROR;
          end else if (clk_s2_q && data_s2_q) begin
            tx_done_q <= 1'b1;
            state_q   <= S_DONE;
          end
        end
        S_DONE, S_ERROR: begin
          clk_oe_q   <= 1'b0;
          data_oe_q  <= 1'b0;
          tx_ready_q <= 1'b1;
          busy_q     <= 1'b0;
          state_q    <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign tx_ready    = tx_ready_q;
  assign tx_done     = tx_done_q;
  assign tx_error    = tx_error_q;
  assign busy        = busy_q;
  assign ps2_clk_oe  = clk_oe_q;
  assign ps2_data_oe = data_oe_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx with a simple PS/2 device model on open-drain lines.
module tb_ps2_host_tx;

  logic       clock;
  logic       reset;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       tx_done;
  logic       tx_error;
  logic       busy;
  logic       ps2_clk_oe;
  logic       ps2_data_oe;

  logic       dev_clk;
  logic       dev_data;
  logic       clk_line;
  logic       data_line;

  int vectors;
  int miscompares;
  int done_cnt;
  int err_cnt;
  int cyc;
  int last_fall_cyc;

  assign clk_line  = ps2_clk_oe  ? 1'b0 : dev_clk;
  assign data_line = ps2_data_oe ? 1'b0 : dev_data;

  ps2_host_tx #(
    .INHIBIT_CYCLES(8),
    .TIMEOUT_CYCLES(100)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .tx_done    (tx_done),
    .tx_error   (tx_error),
    .busy       (busy),
    .ps2_clk_in (clk_line),
    .ps2_data_in(data_line),
    .ps2_clk_oe (ps2_clk_oe),
    .ps2_data_oe(ps2_data_oe)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Pulse-cycle counters and a free-running cycle count
  always @(posedge clock) begin
    cyc <= cyc + 1;
    if (tx_done === 1'b1) done_cnt <= done_cnt + 1;
    if (tx_error === 1'b1) err_cnt <= err_cnt + 1;
  end

  initial begin
    #3000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  // Device: wait for RTS, clock n_falls falls at 40-cycle period, record line at rising edges
  task automatic dev_frame(input int n_falls, input bit ack, output logic [10:0] bits);
    int t;
    bits = 'x;
    t = 0;
    while (!(ps2_clk_oe === 1'b0 && ps2_data_oe === 1'b1) && t < 200) begin
      @(negedge clock);
      t++;
    end
    if (t >= 200) return;
    repeat (20) @(negedge clock);
    bits[0] = data_line;
    for (int k = 1; k <= n_falls; k++) begin
      dev_clk = 1'b0;
      last_fall_cyc = cyc;
      repeat (20) @(negedge clock);
      dev_clk = 1'b1;
      if (k == 11) begin
        dev_data = 1'b1;
        return;
      end
      bits[k] = data_line;
      if (k == 10 && ack) begin
        repeat (10) @(negedge clock);
        dev_data = 1'b0;
        repeat (10) @(negedge clock);
      end else begin
        repeat (20) @(negedge clock);
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clock);
    vectors++; if (tx_ready !== 1'b1) begin miscompares++; $display("FAIL reset_tx_ready: got %b expected 1", tx_ready); end
    vectors++; if (tx_done !== 1'b0) begin miscompares++; $display("FAIL reset_tx_done: got %b expected 0", tx_done); end
    vectors++; if (tx_error !== 1'b0) begin miscompares++; $display("FAIL reset_tx_error: got %b expected 0", tx_error); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b expected 0", busy); end
    vectors++; if (ps2_clk_oe !== 1'b0) begin miscompares++; $display("FAIL reset_clk_oe: got %b expected 0", ps2_clk_oe); end
    vectors++; if (ps2_data_oe !== 1'b0) begin miscompares++; $display("FAIL reset_data_oe: got %b expected 0", ps2_data_oe); end
    reset = 1'b0;
    repeat (2) @(negedge clock);
  endtask

  task automatic test_send_f4();
    logic [10:0] bits;
    int hi;
    logic rdy1, busy1, doe1, doe9;
    done_cnt = 0; err_cnt = 0;
    @(negedge clock); tx_data = 8'hF4; tx_valid = 1'b1;
    @(negedge clock); tx_valid = 1'b0; tx_data = 8'h00;
    hi = 0; rdy1 = 1'bx; busy1 = 1'bx; doe1 = 1'bx; doe9 = 1'bx;
    while (ps2_clk_oe === 1'b1 && hi < 100) begin
      hi++;
      if (hi == 1) begin rdy1 = tx_ready; busy1 = busy; doe1 = ps2_data_oe; end
      if (hi == 9) doe9 = ps2_data_oe;
      @(negedge clock);
    end
    vectors++; if (hi !== 9) begin miscompares++; $display("FAIL f4_clk_oe_cycles: got %0d expected 9", hi); end
    vectors++; if (rdy1 !== 1'b0 || busy1 !== 1'b1) begin miscompares++; $display("FAIL f4_accept_flags: ready=%b busy=%b expected ready=0 busy=1", rdy1, busy1); end
    vectors++; if (doe1 !== 1'b0 || doe9 !== 1'b1) begin miscompares++; $display("FAIL f4_data_oe_rts: inhibit=%b rts=%b expected 0 and 1", doe1, doe9); end
    vectors++; if (ps2_data_oe !== 1'b1) begin miscompares++; $display("FAIL f4_start_bit_oe: got %b expected 1", ps2_data_oe); end
    dev_frame(11, 1'b1, bits);
    vectors++; if (bits !== {1'b1, 1'b0, 8'hF4, 1'b0}) begin miscompares++; $display("FAIL f4_frame: got %b expected %b", bits, {1'b1, 1'b0, 8'hF4, 1'b0}); end
    for (int t = 0; t < 50 && tx_ready !== 1'b1; t++) @(negedge clock);
    @(negedge clock);
    vectors++; if (done_cnt !== 1 || err_cnt !== 0) begin miscompares++; $display("FAIL f4_pulses: done=%0d error=%0d expected 1 and 0", done_cnt, err_cnt); end
  endtask

  task automatic test_send(input logic [7:0] b, input logic [10:0] exp);
    logic [10:0] bits;
    done_cnt = 0; err_cnt = 0;
    @(negedge clock); tx_data = b; tx_valid = 1'b1;
    @(negedge clock); tx_valid = 1'b0;
    dev_frame(11, 1'b1, bits);
    vectors++; if (bits !== exp) begin miscompares++; $display("FAIL send_%h_frame: got %b expected %b", b, bits, exp); end
    for (int t = 0; t < 50 && tx_ready !== 1'b1; t++) @(negedge clock);
    @(negedge clock);
    vectors++; if (done_cnt !== 1 || err_cnt !== 0 || tx_ready !== 1'b1) begin miscompares++; $display("FAIL send_%h_done: done=%0d error=%0d ready=%b expected 1 0 1", b, done_cnt, err_cnt, tx_ready); end
  endtask

  task automatic test_no_ack();
    logic [10:0] bits;
    done_cnt = 0; err_cnt = 0;
    @(negedge clock); tx_data = 8'hF4; tx_valid = 1'b1;
    @(negedge clock); tx_valid = 1'b0;
    dev_frame(11, 1'b0, bits);
    for (int t = 0; t < 50 && tx_ready !== 1'b1; t++) @(negedge clock);
    repeat (5) @(negedge clock);
    vectors++; if (err_cnt !== 1) begin miscompares++; $display("FAIL noack_error: got %0d pulse cycles expected 1", err_cnt); end
    vectors++; if (done_cnt !== 0) begin miscompares++; $display("FAIL noack_done: got %0d pulse cycles expected 0", done_cnt); end
    vectors++; if (tx_ready !== 1'b1 || busy !== 1'b0) begin miscompares++; $display("FAIL noack_ready: ready=%b busy=%b expected 1 0", tx_ready, busy); end
  endtask

  task automatic test_timeout();
    logic [10:0] bits;
    int t;
    done_cnt = 0; err_cnt = 0;
    @(negedge clock); tx_data = 8'hF4; tx_valid = 1'b1;
    @(negedge clock); tx_valid = 1'b0;
    dev_frame(4, 1'b1, bits);
`ifdef PS2_TX_TIMEOUT_EN
    t = 0;
    while (tx_error !== 1'b1 && t < 300) begin @(negedge clock); t++; end
    vectors++; if (cyc - last_fall_cyc !== 103) begin miscompares++; $display("FAIL timeout_latency: got %0d cycles from pin fall expected 103", cyc - last_fall_cyc); end
    vectors++; if (ps2_clk_oe !== 1'b0 || ps2_data_oe !== 1'b0) begin miscompares++; $display("FAIL timeout_oe: clk_oe=%b data_oe=%b expected 0 0", ps2_clk_oe, ps2_data_oe); end
    repeat (3) @(negedge clock);
    vectors++; if (err_cnt !== 1 || tx_ready !== 1'b1) begin miscompares++; $display("FAIL timeout_pulse: error=%0d ready=%b expected 1 1", err_cnt, tx_ready); end
`else
    t = 0;
    while (tx_error !== 1'b1 && t < 300) begin @(negedge clock); t++; end
    vectors++; if (err_cnt !== 0 || busy !== 1'b1 || tx_ready !== 1'b0) begin miscompares++; $display("FAIL stall_no_timeout: error=%0d busy=%b ready=%b expected 0 1 0", err_cnt, busy, tx_ready); end
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    repeat (2) @(negedge clock);
`endif
  endtask

  task automatic test_reset_mid_shift();
    logic [10:0] bits;
    done_cnt = 0; err_cnt = 0;
    @(negedge clock); tx_data = 8'h00; tx_valid = 1'b1;
    @(negedge clock); tx_valid = 1'b0;
    dev_frame(6, 1'b1, bits);
    vectors++; if (ps2_data_oe !== 1'b1 || busy !== 1'b1) begin miscompares++; $display("FAIL midshift_pre: data_oe=%b busy=%b expected 1 1", ps2_data_oe, busy); end
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    vectors++; if (tx_ready !== 1'b1 || busy !== 1'b0) begin miscompares++; $display("FAIL midshift_ready: ready=%b busy=%b expected 1 0", tx_ready, busy); end
    vectors++; if (ps2_clk_oe !== 1'b0 || ps2_data_oe !== 1'b0) begin miscompares++; $display("FAIL midshift_oe: clk_oe=%b data_oe=%b expected 0 0", ps2_clk_oe, ps2_data_oe); end
    repeat (3) @(negedge clock);
    vectors++; if (done_cnt !== 0 || err_cnt !== 0) begin miscompares++; $display("FAIL midshift_pulses: done=%0d error=%0d expected 0 0", done_cnt, err_cnt); end
    test_send(8'h01, {1'b1, 1'b0, 8'h01, 1'b0});
  endtask

  task automatic test_back_to_back();
    logic [10:0] bits;
    int t;
    done_cnt = 0; err_cnt = 0;
    @(negedge clock); tx_data = 8'hAA; tx_valid = 1'b1;
    t = 0;
    while (busy !== 1'b1 && t < 20) begin @(negedge clock); t++; end
    tx_data = 8'h55;
    dev_frame(11, 1'b1, bits);
    vectors++; if (bits !== {1'b1, 1'b1, 8'hAA, 1'b0}) begin miscompares++; $display("FAIL b2b_first_frame: got %b expected %b", bits, {1'b1, 1'b1, 8'hAA, 1'b0}); end
    t = 0;
    while (tx_done !== 1'b1 && t < 50) begin @(negedge clock); t++; end
    vectors++; if (tx_done !== 1'b1 || tx_ready !== 1'b0) begin miscompares++; $display("FAIL b2b_done_cycle: done=%b ready=%b expected 1 0", tx_done, tx_ready); end
    @(negedge clock);
    vectors++; if (tx_ready !== 1'b1 || busy !== 1'b0 || tx_done !== 1'b0) begin miscompares++; $display("FAIL b2b_idle_cycle: ready=%b busy=%b done=%b expected 1 0 0", tx_ready, busy, tx_done); end
    @(negedge clock);
    vectors++; if (busy !== 1'b1 || ps2_clk_oe !== 1'b1) begin miscompares++; $display("FAIL b2b_second_accept: busy=%b clk_oe=%b expected 1 1", busy, ps2_clk_oe); end
    tx_valid = 1'b0;
    dev_frame(11, 1'b1, bits);
    vectors++; if (bits !== {1'b1, 1'b1, 8'h55, 1'b0}) begin miscompares++; $display("FAIL b2b_second_frame: got %b expected %b", bits, {1'b1, 1'b1, 8'h55, 1'b0}); end
    for (int k = 0; k < 50 && tx_ready !== 1'b1; k++) @(negedge clock);
    @(negedge clock);
    vectors++; if (done_cnt !== 2 || err_cnt !== 0) begin miscompares++; $display("FAIL b2b_pulses: done=%0d error=%0d expected 2 0", done_cnt, err_cnt); end
  endtask

  initial begin
    vectors = 0; miscompares = 0;
    done_cnt = 0; err_cnt = 0; cyc = 0; last_fall_cyc = 0;
    reset = 1'b1; tx_data = 8'h00; tx_valid = 1'b0;
    dev_clk = 1'b1; dev_data = 1'b1;
    test_reset();
    test_send_f4();
    test_send(8'hED, {1'b1, 1'b1, 8'hED, 1'b0});
    test_send(8'h00, {1'b1, 1'b1, 8'h00, 1'b0});
    test_send(8'hFF, {1'b1, 1'b1, 8'hFF, 1'b0});
    test_no_ack();
    test_timeout();
    test_reset_mid_shift();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
